snr_accum: RTL and testbench

Sample-domain accumulator for SNR measurement. It runs on the system clock and takes the divided sample clock from the clock divider as a level input. On each rising edge of that sample clock it captures one ADC word and accumulates the sum and sum of squares over a frame of 2^LOG2N samples. Each finished frame is presented to the downstream SNR computation over a valid/ready handshake.

---
 rtl/snr_pkg.sv | 15 +
 rtl/smp_edge.sv | 18 +
 rtl/snr_accum.sv | 129 ++++++++++++
 tb/tb_snr_accum.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/snr_pkg.sv
// Shared types and default widths for the SNR sample accumulator.
package snr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } snr_state_e;

  localparam int unsigned DW_DEF    = 12;
  localparam int unsigned LOG2N_DEF = 10;
  localparam int unsigned SUM_W     = DW_DEF + LOG2N_DEF;
  localparam int unsigned SQ_W      = 2 * DW_DEF + LOG2N_DEF;

endpackage

// File: rtl/smp_edge.sv
// Rising-edge detector for the divided sample clock, treated as a data level.
module smp_edge (
  input  logic clk_in,
  input  logic rest,
  input  logic smp_clk,
  output logic smp_edge_c
);

  logic r_smp_d;

  always_ff @(posedge clk_in) begin
    if (rest) r_smp_d <= 1'b0;
    else      r_smp_d <= smp_clk;
  end

  assign smp_edge_c = smp_clk & ~r_smp_d;

endmodule

// File: rtl/snr_accum.sv
// Frame accumulator of sum and sum of squares over 2^LOG2N ADC samples.
// Optional running max/min of the frame when SNR_PEAK_EN is defined.
module snr_accum
  import snr_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned LOG2N = LOG2N_DEF
) (
  input  logic                          clk_in,
  input  logic                          rest,
  input  logic                          smp_clk,
  input  logic signed [DW-1:0]          adc_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          overrun,
  output logic                          res_valid,
  input  logic                          res_ready,
`ifdef SNR_PEAK_EN
  output logic signed [DW-1:0]          res_max,
  output logic signed [DW-1:0]          res_min,
`endif
  output logic signed [DW+LOG2N-1:0]    res_sum,
  output logic        [2*DW+LOG2N-1:0]  res_sumsq
);

  localparam int unsigned W_SUM = DW + LOG2N;
  localparam int unsigned W_SQ  = 2 * DW + LOG2N;

  snr_state_e               r_state;
  logic [LOG2N-1:0]         r_cnt;
  logic signed [W_SUM-1:0]  r_acc_sum;
  logic [W_SQ-1:0]          r_acc_sq;

  logic                     w_edge;
  logic                     w_last;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [W_SUM-1:0]  w_sum_next;
  logic [W_SQ-1:0]          w_sq_next;

  smp_edge u_smp_edge (
    .clk_in     (clk_in),
    .rest       (rest),
    .smp_clk    (smp_clk),
    .smp_edge_c (w_edge)
  );

  // Square of a signed sample is never negative, so zero-extension is exact.
  assign w_prod     = adc_data * adc_data;
  assign w_sum_next = r_acc_sum + W_SUM'(adc_data);
  assign w_sq_next  = r_acc_sq + W_SQ'($unsigned(w_prod));
  assign w_last     = &r_cnt;

`ifdef SNR_PEAK_EN
  logic signed [DW-1:0] r_max, r_min;
  logic signed [DW-1:0] w_max_next, w_min_next;

  // The first sample of a frame seeds both extremes.
  assign w_max_next = ((r_cnt == '0) || (adc_data > r_max)) ? adc_data : r_max;
  assign w_min_next = ((r_cnt == '0) || (adc_data < r_min)) ? adc_data : r_min;
`endif

  always_ff @(posedge clk_in) begin
    if (rest) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc_sum <= '0;
      r_acc_sq  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_sumsq <= '0;
`ifdef SNR_PEAK_EN
      r_max     <= '0;
      r_min     <= '0;
      res_max   <= '0;
      res_min   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ACCUM;
            busy      <= 1'b1;
            overrun   <= 1'b0;
            r_cnt     <= '0;
            r_acc_sum <= '0;
            r_acc_sq  <= '0;
          end
        end
        S_ACCUM: begin
          if (start) overrun <= 1'b1;
          if (w_edge) begin
            r_acc_sum <= w_sum_next;
            r_acc_sq  <= w_sq_next;
            r_cnt     <= r_cnt + LOG2N'(1);
`ifdef SNR_PEAK_EN
            r_max     <= w_max_next;
            r_min     <= w_min_next;
`endif
            if (w_last) begin
              res_sum   <= w_sum_next;
              res_sumsq <= w_sq_next;
`ifdef SNR_PEAK_EN
              res_max   <= w_max_next;
              res_min   <= w_min_next;
`endif
              res_valid <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (start) overrun <= 1'b1;
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snr_accum.sv
// Directed bench for snr_accum with N=4 and a divide-by-10 sample clock.
// Peak outputs are checked only when built with SNR_PEAK_EN.
module tb_snr_accum;

  localparam int unsigned DW    = 12;
  localparam int unsigned LOG2N = 2;

  logic                          clk_in;
  logic                          rest;
  logic                          smp_clk;
  logic signed [DW-1:0]          adc_data;
  logic                          start;
  logic                          busy;
  logic                          overrun;
  logic                          res_valid;
  logic                          res_ready;
  logic signed [DW+LOG2N-1:0]    res_sum;
  logic        [2*DW+LOG2N-1:0]  res_sumsq;
`ifdef SNR_PEAK_EN
  logic signed [DW-1:0]          res_max;
  logic signed [DW-1:0]          res_min;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  logic vld_after_edge;

  snr_accum #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk_in    (clk_in),
    .rest      (rest),
    .smp_clk   (smp_clk),
    .adc_data  (adc_data),
    .start     (start),
    .busy      (busy),
    .overrun   (overrun),
    .res_valid (res_valid),
    .res_ready (res_ready),
`ifdef SNR_PEAK_EN
    .res_max   (res_max),
    .res_min   (res_min),
`endif
    .res_sum   (res_sum),
    .res_sumsq (res_sumsq)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 10-cycle sample-clock period; called and returns at a negedge.
  task automatic smp(input int v);
    adc_data = DW'(v);
    smp_clk  = 1'b1;
    @(negedge clk_in);
    vld_after_edge = res_valid;
    repeat (4) @(negedge clk_in);
    smp_clk = 1'b0;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk_in);
    res_ready = 1'b0;
  endtask

  initial begin
    rest = 1'b1; smp_clk = 1'b0; adc_data = '0; start = 1'b0; res_ready = 1'b0;
    vld_after_edge = 1'b0;
    repeat (3) @(negedge clk_in);
    rest = 1'b0;
    check("rst_busy", 64'(busy), 0);
    check("rst_overrun", 64'(overrun), 0);
    check("rst_valid", 64'(res_valid), 0);
    check("rst_sum", 64'(res_sum), 0);
    check("rst_sumsq", 64'(res_sumsq), 0);
`ifdef SNR_PEAK_EN
    check("rst_max", 64'(res_max), 0);
    check("rst_min", 64'(res_min), 0);
`endif

    // Alternating +/-100
    pulse_start();
    check("a_busy_rise", 64'(busy), 1);
    smp(100); smp(-100); smp(100);
    check("a_vld_after3", 64'(vld_after_edge), 0);
    smp(-100);
    check("a_vld_after4", 64'(vld_after_edge), 1);
    check("a_sum", 64'(res_sum), 0);
    check("a_sumsq", 64'(res_sumsq), 40000);
`ifdef SNR_PEAK_EN
    check("a_max", 64'(res_max), 100);
    check("a_min", 64'(res_min), -100);
`endif
    accept();
    check("a_vld_fall", 64'(res_valid), 0);
    check("a_busy_fall", 64'(busy), 0);

    // Positive full scale, new start in the cycle right after accept
    pulse_start();
    repeat (4) smp(2047);
    check("p_sum", 64'(res_sum), 8188);
    check("p_sumsq", 64'(res_sumsq), 16760836);
`ifdef SNR_PEAK_EN
    check("p_max", 64'(res_max), 2047);
    check("p_min", 64'(res_min), 2047);
`endif
    accept();

    // Negative full scale, then hold off ready with edges arriving in DONE
    pulse_start();
    repeat (4) smp(-2048);
    check("n_sum", 64'(res_sum), -8192);
    check("n_sumsq", 64'(res_sumsq), 16777216);
    smp(5); smp(5); smp(5);
    check("hold_valid", 64'(res_valid), 1);
    check("hold_busy", 64'(busy), 1);
    check("hold_sum", 64'(res_sum), -8192);
    check("hold_sumsq", 64'(res_sumsq), 16777216);
`ifdef SNR_PEAK_EN
    check("hold_min", 64'(res_min), -2048);
`endif
    accept();
    smp(7);
    check("idle_busy", 64'(busy), 0);
    check("idle_valid", 64'(res_valid), 0);
    check("idle_sum", 64'(res_sum), -8192);

    // Overrun: start during ACCUM is ignored but flagged
    pulse_start();
    smp(3);
    pulse_start();
    check("ovr_set", 64'(overrun), 1);
    smp(3); smp(3);
    check("ovr_vld_after3", 64'(vld_after_edge), 0);
    smp(3);
    check("ovr_vld_after4", 64'(vld_after_edge), 1);
    check("ovr_sum", 64'(res_sum), 12);
    check("ovr_sumsq", 64'(res_sumsq), 36);
    accept();
    check("ovr_sticky", 64'(overrun), 1);
    pulse_start();
    check("ovr_clear", 64'(overrun), 0);

    // Reset mid-frame discards partial sums and clears everything
    smp(1); smp(1);
    pulse_start();
    rest = 1'b1;
    @(negedge clk_in);
    rest = 1'b0;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_overrun", 64'(overrun), 0);
    check("mid_rst_valid", 64'(res_valid), 0);
    check("mid_rst_sum", 64'(res_sum), 0);
    check("mid_rst_sumsq", 64'(res_sumsq), 0);
    pulse_start();
    smp(1); smp(2); smp(3); smp(4);
    check("r_valid", 64'(res_valid), 1);
    check("r_sum", 64'(res_sum), 10);
    check("r_sumsq", 64'(res_sumsq), 30);
    accept();

    // Start coincident with a sample edge: that sample is excluded
    start = 1'b1; adc_data = DW'(1000); smp_clk = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (4) @(negedge clk_in);
    smp_clk = 1'b0;
    repeat (5) @(negedge clk_in);
    smp(5); smp(6); smp(7);
    check("c_vld_after3", 64'(vld_after_edge), 0);
    smp(8);
    check("c_vld_after4", 64'(vld_after_edge), 1);
    check("c_sum", 64'(res_sum), 26);
    check("c_sumsq", 64'(res_sumsq), 174);
`ifdef SNR_PEAK_EN
    check("c_max", 64'(res_max), 8);
    check("c_min", 64'(res_min), 5);
`endif
    accept();
    check("c_busy_fall", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
